// File: rtl/multi_axis_angle_controller.sv
// Time-shared angle/rate command generator: one datapath walks every axis
// through MAP, SCALE and LIMIT slots after a start request.
module multi_axis_angle_controller #(
  parameter int unsigned                NUM_AXES     = 3,
  parameter int unsigned                REC_W        = 8,
  parameter int unsigned                RATE_W       = 16,
  parameter int unsigned                MAP_SHIFT    = 1,
  parameter int                         MAP_OFFSET   = 250,
  parameter logic signed [RATE_W-1:0]   GAIN         = 16'sd8,
  parameter int unsigned                GAIN_FRAC    = 4,
  parameter int                         LIMIT        = 400,
  parameter int                         SLEW_MAX     = 0,
  parameter logic [NUM_AXES-1:0]        ANGLE_MASK   = 3'b110,
  parameter logic [NUM_AXES-1:0]        ACT_ADD_MASK = 3'b010
) (
  input  logic                         us_clk,
  input  logic                         reset,
  input  logic                         start_signal,
  input  logic [NUM_AXES*REC_W-1:0]    target_in,
  input  logic [NUM_AXES*RATE_W-1:0]   actual_in,
  output logic [NUM_AXES*RATE_W-1:0]   rate_out,
  output logic [NUM_AXES*RATE_W-1:0]   angle_error,
  output logic                         active_signal,
  output logic                         complete_signal
);

  localparam int unsigned IDX_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam int unsigned MW    = RATE_W + 2;
  localparam int unsigned PW    = 2 * RATE_W;
  localparam int unsigned DW    = RATE_W + 1;

  localparam logic signed [MW-1:0]     E_MAX  = {3'b000, {(RATE_W-1){1'b1}}};
  localparam logic signed [MW-1:0]     E_MIN  = {3'b111, {(RATE_W-1){1'b0}}};
  localparam logic signed [PW-1:0]     P_MAX  = {{(RATE_W+1){1'b0}}, {(RATE_W-1){1'b1}}};
  localparam logic signed [PW-1:0]     P_MIN  = {{(RATE_W+1){1'b1}}, {(RATE_W-1){1'b0}}};
  localparam logic signed [RATE_W-1:0] LIM_P  = RATE_W'(LIMIT);
  localparam logic signed [RATE_W-1:0] LIM_N  = RATE_W'(-LIMIT);
  localparam logic signed [DW-1:0]     SLEW_P = DW'(SLEW_MAX);
  localparam logic signed [DW-1:0]     SLEW_N = DW'(-SLEW_MAX);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH    = 3'd1,
    S_MAP      = 3'd2,
    S_SCALE    = 3'd3,
    S_LIMIT    = 3'd4,
    S_COMPLETE = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic                                start_d, start_q, pending;
  logic                                request_c, last_c;
  logic [IDX_W-1:0]                    idx;
  logic [NUM_AXES-1:0][REC_W-1:0]      tgt_lat;
  logic [NUM_AXES-1:0][RATE_W-1:0]     act_lat;
  logic [NUM_AXES-1:0][RATE_W-1:0]     rate_q;
  logic [NUM_AXES-1:0][RATE_W-1:0]     err_q;
  logic signed [RATE_W-1:0]            e_reg, s_reg;

  logic signed [MW-1:0]                m_c, act_c, sum_c;
  logic signed [RATE_W-1:0]            e_c;
  logic signed [PW-1:0]                p_c, sh_c;
  logic signed [RATE_W-1:0]            s_c;
  logic signed [RATE_W-1:0]            c_c, prev_c, r_c;
  logic signed [DW-1:0]                d_c;

  // start_signal is registered once before edge detection, so a request is
  // seen one edge after the input is sampled and LATCH follows on the next.
  assign request_c = start_d & ~start_q;
  assign last_c    = (idx == IDX_W'(NUM_AXES - 1));

  assign rate_out    = rate_q;
  assign angle_error = err_q;

  always_ff @(posedge us_clk) begin
    if (reset) begin
      state           <= S_IDLE;
      start_d         <= 1'b0;
      start_q         <= 1'b0;
      pending         <= 1'b0;
      active_signal   <= 1'b0;
      complete_signal <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_d <= start_signal;
      start_q <= start_d;
      if (state == S_IDLE && state_nxt == S_LATCH) begin
        pending <= 1'b0;
      end else if (request_c && state != S_IDLE) begin
        pending <= 1'b1;
      end
      active_signal   <= (state_nxt == S_LATCH) || (state_nxt == S_MAP) ||
                         (state_nxt == S_SCALE) || (state_nxt == S_LIMIT);
      complete_signal <= (state_nxt == S_COMPLETE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (request_c || pending) state_nxt = S_LATCH;
      S_LATCH:    state_nxt = S_MAP;
      S_MAP:      state_nxt = S_SCALE;
      S_SCALE:    state_nxt = S_LIMIT;
      S_LIMIT:    state_nxt = last_c ? S_COMPLETE : S_MAP;
      S_COMPLETE: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Map slot: offset target, combine with the IMU angle, saturate.
  always_comb begin
    m_c   = signed'(MW'(tgt_lat[idx]) << MAP_SHIFT) - signed'(MW'(MAP_OFFSET));
    act_c = MW'(signed'(act_lat[idx]));
    sum_c = m_c;
    if (ANGLE_MASK[idx]) begin
      sum_c = ACT_ADD_MASK[idx] ? (m_c + act_c) : (m_c - act_c);
    end
    if (sum_c > E_MAX) begin
      e_c = E_MAX[RATE_W-1:0];
    end else if (sum_c < E_MIN) begin
      e_c = E_MIN[RATE_W-1:0];
    end else begin
      e_c = sum_c[RATE_W-1:0];
    end
  end

  // Scale slot: full-width product, fixed-point shift, saturate.
  always_comb begin
    p_c  = PW'(e_reg) * PW'(GAIN);
    sh_c = p_c >>> GAIN_FRAC;
    if (sh_c > P_MAX) begin
      s_c = P_MAX[RATE_W-1:0];
    end else if (sh_c < P_MIN) begin
      s_c = P_MIN[RATE_W-1:0];
    end else begin
      s_c = sh_c[RATE_W-1:0];
    end
  end

  // Limit slot: symmetric clamp, then optional slew against the held output.
  always_comb begin
    c_c = s_reg;
    if (s_reg > LIM_P) begin
      c_c = LIM_P;
    end else if (s_reg < LIM_N) begin
      c_c = LIM_N;
    end
    prev_c = signed'(rate_q[idx]);
    d_c    = DW'(c_c) - DW'(prev_c);
    if (d_c > SLEW_P) begin
      d_c = SLEW_P;
    end else if (d_c < SLEW_N) begin
      d_c = SLEW_N;
    end
    r_c = (SLEW_MAX != 0) ? RATE_W'(DW'(prev_c) + d_c) : c_c;
  end

  always_ff @(posedge us_clk) begin
    if (reset) begin
      idx     <= '0;
      tgt_lat <= '0;
      act_lat <= '0;
      e_reg   <= '0;
      s_reg   <= '0;
      rate_q  <= '0;
      err_q   <= '0;
    end else begin
      case (state)
        S_LATCH: begin
          tgt_lat <= target_in;
          act_lat <= actual_in;
          idx     <= '0;
        end
        S_MAP:   e_reg <= e_c;
        S_SCALE: s_reg <= s_c;
        S_LIMIT: begin
          rate_q[idx] <= r_c;
          err_q[idx]  <= e_reg;
          if (!last_c) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_axis_angle_controller.sv
// Scoreboard bench: three controller variants share stimulus; a monitor pops
// model predictions on every complete pulse.
module tb_multi_axis_angle_controller;

  typedef struct packed {
    logic [47:0] rate;
    logic [47:0] err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] target = '0;
  logic [47:0] actual = '0;
  logic [47:0] rate [3];
  logic [47:0] err [3];
  logic        active [3];
  logic        complete [3];

  int n_chk = 0;
  int n_fail = 0;

  exp_t exp_q [3][$];

  // Model configuration per instance: gain, fraction shift, slew, add mask.
  int         gain_p [3] = '{8, 8, 32767};
  int         frac_p [3] = '{4, 4, 0};
  int         slew_p [3] = '{0, 50, 0};
  logic [2:0] add_p  [3] = '{3'b010, 3'b010, 3'b000};
  logic [2:0] angle_m    = 3'b110;
  int         prev [3][3];

  always #5 clk = ~clk;

  multi_axis_angle_controller u_dut0 (
    .us_clk(clk), .reset(reset), .start_signal(start), .target_in(target),
    .actual_in(actual), .rate_out(rate[0]), .angle_error(err[0]),
    .active_signal(active[0]), .complete_signal(complete[0]));

  multi_axis_angle_controller #(.SLEW_MAX(50)) u_dut1 (
    .us_clk(clk), .reset(reset), .start_signal(start), .target_in(target),
    .actual_in(actual), .rate_out(rate[1]), .angle_error(err[1]),
    .active_signal(active[1]), .complete_signal(complete[1]));

  multi_axis_angle_controller #(.GAIN(16'sh7FFF), .GAIN_FRAC(0), .ACT_ADD_MASK(3'b000)) u_dut2 (
    .us_clk(clk), .reset(reset), .start_signal(start), .target_in(target),
    .actual_in(actual), .rate_out(rate[2]), .angle_error(err[2]),
    .active_signal(active[2]), .complete_signal(complete[2]));

  task automatic chk(input string nm, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, want, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint lo, input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Plain-integer reference for one run; updates the slew history.
  function automatic exp_t predict(input int d, input logic [23:0] tgt, input logic [47:0] act);
    exp_t   x;
    longint m, a, e, s, c, r;
    x = '0;
    for (int i = 0; i < 3; i++) begin
      m = longint'(tgt[i*8 +: 8]) * 2 - 250;
      a = longint'($signed(act[i*16 +: 16]));
      e = m;
      if (angle_m[i]) e = add_p[d][i] ? (m + a) : (m - a);
      e = sat(e, -32768, 32767);
      s = sat((e * longint'(gain_p[d])) >>> frac_p[d], -32768, 32767);
      c = sat(s, -400, 400);
      if (slew_p[d] != 0) r = prev[d][i] + sat(c - prev[d][i], -slew_p[d], slew_p[d]);
      else r = c;
      prev[d][i] = int'(r);
      x.rate[i*16 +: 16] = 16'(r);
      x.err[i*16 +: 16]  = 16'(e);
    end
    return x;
  endfunction

  function automatic logic [47:0] rand_act();
    logic [47:0] a;
    for (int i = 0; i < 3; i++) begin
      if ($urandom_range(0, 3) == 0) a[i*16 +: 16] = 16'($urandom);
      else a[i*16 +: 16] = 16'($urandom_range(0, 4000) - 2000);
    end
    return a;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (complete[d]) begin
        chk($sformatf("d%0d_active_with_complete", d), longint'(active[d]), 0);
        chk($sformatf("d%0d_expected_run", d), longint'(exp_q[d].size() > 0), 1);
        if (exp_q[d].size() > 0) begin
          exp_t x;
          x = exp_q[d].pop_front();
          chk($sformatf("d%0d_rate", d), longint'(rate[d]), longint'(x.rate));
          chk($sformatf("d%0d_err", d), longint'(err[d]), longint'(x.err));
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) exp_q[d].delete();
    prev = '{default: 0};
  endtask

  task automatic check_zero(input string nm);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_d%0d_rate", nm, d), longint'(rate[d]), 0);
      chk($sformatf("%s_d%0d_err", nm, d), longint'(err[d]), 0);
      chk($sformatf("%s_d%0d_active", nm, d), longint'(active[d]), 0);
      chk($sformatf("%s_d%0d_complete", nm, d), longint'(complete[d]), 0);
    end
  endtask

  // One request; checks latency and active width; optionally scrambles
  // inputs once they have been latched.
  task automatic run_once(input logic [23:0] t, input logic [47:0] a, input bit scramble);
    int cyc, act_cnt;
    bit done;
    target = t;
    actual = a;
    for (int d = 0; d < 3; d++) exp_q[d].push_back(predict(d, t, a));
    start = 1'b1;
    cyc = 0;
    act_cnt = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 3 && scramble) begin
        target = 24'($urandom);
        actual = rand_act();
      end
      if (active[0]) act_cnt++;
      if (complete[0]) done = 1'b1;
    end
    chk("run_completed", longint'(done), 1);
    chk("run_latency", cyc - 1, 11);
    chk("active_cycles", act_cnt, 10);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_handshake();
    int ncomp, first, second;
    target = 24'($urandom);
    actual = rand_act();
    for (int d = 0; d < 3; d++) begin
      exp_q[d].push_back(predict(d, target, actual));
      exp_q[d].push_back(predict(d, target, actual));
    end
    start = 1'b1;
    ncomp = 0;
    first = 0;
    second = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      case (cyc)
        1, 4, 7: start = 1'b0;
        3, 6:    start = 1'b1;
        default: ;
      endcase
      if (complete[0]) begin
        ncomp++;
        if (ncomp == 1) first = cyc;
        else second = cyc;
      end
    end
    chk("hs_pulses", ncomp, 2);
    chk("hs_first", first, 12);
    chk("hs_gap", second - first, 12);
  endtask

  task automatic run_abort();
    int nc;
    nc = 0;
    target = 24'($urandom);
    actual = rand_act();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    prev = '{default: 0};
    check_zero("abort");
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (complete[0] || complete[1] || complete[2]) nc++;
    end
    chk("abort_no_complete", nc, 0);
  endtask

  initial begin
    do_reset();
    check_zero("reset");

    run_once({8'd125, 8'd125, 8'd250}, {16'd1000, 16'h0320, 16'd0}, 1'b0);
    chk("d0_rate0_map250", longint'(rate[0][15:0]), 16'h007D);
    chk("d0_rate2_clamp", longint'(rate[0][47:32]), 16'hFE70);
    chk("d2_err1_sub", longint'(err[2][31:16]), 16'hFCE0);
    chk("d2_rate1_sub", longint'(rate[2][31:16]), 16'hFE70);
    chk("d1_slew_run1", longint'(rate[1][15:0]), 50);

    run_once({8'd125, 8'd125, 8'd250}, {16'd1000, 16'h0320, 16'd0}, 1'b0);
    chk("d1_slew_run2", longint'(rate[1][15:0]), 100);
    run_once({8'd125, 8'd125, 8'd250}, {16'd1000, 16'h0320, 16'd0}, 1'b1);
    chk("d1_slew_run3", longint'(rate[1][15:0]), 125);

    run_once({8'd125, 8'd125, 8'd0}, {16'd1000, 16'h0320, 16'd0}, 1'b0);
    chk("d1_slew_down", longint'(rate[1][15:0]), 75);
    chk("d0_rate0_neg", longint'(rate[0][15:0]), 16'hFF83);

    run_once({8'd0, 8'd150, 8'd125}, {16'd0, 16'd40, 16'd0}, 1'b0);
    chk("d0_add_err1", longint'(err[0][31:16]), 90);
    chk("d0_add_rate1", longint'(rate[0][31:16]), 45);
    chk("d0_rate0_zero", longint'(rate[0][15:0]), 0);

    run_once({8'd0, 8'd0, 8'd255}, '0, 1'b0);
    chk("d2_sat_rate0", longint'(rate[2][15:0]), 400);
    chk("d2_sat_rate1", longint'(rate[2][31:16]), 16'hFE70);

    run_handshake();
    repeat (3) @(negedge clk);

    for (int k = 0; k < 30; k++) run_once(24'($urandom), rand_act(), 1'b1);

    run_abort();
    for (int k = 0; k < 5; k++) run_once(24'($urandom), rand_act(), 1'b1);

    for (int d = 0; d < 3; d++) chk($sformatf("d%0d_queue_drained", d), exp_q[d].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
